// File: rtl/ram_arbiter.sv
// Data-first arbiter sharing one single-port word RAM between instruction fetch
// and load/store, with a fetch starvation guard and address legality filtering.
package rv32i_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;
endpackage

module ram_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned RAM_WORDS      = 1024,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    output logic        d_resp_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output mem_op_e     ram_mem_op,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [3:0]  BURST_MAX  = 4'(MAX_DATA_BURST);
    localparam logic [32:0] ADDR_LIMIT = 33'(RAM_WORDS) << 2;

    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < ADDR_LIMIT);
    endfunction

    logic [3:0]  streak;
    logic        burst_full;
    logic        grant_if_p0;
    logic        grant_d_p0;
    logic        any_grant_p0;
    logic [31:0] gnt_addr_p0;
    logic        legal_p0;
    owner_e      resp_owner_p1;
    logic        resp_err_p1;

    // Stage p0: combinational grant and RAM issue
    assign burst_full   = (streak == BURST_MAX);
    assign grant_if_p0  = rst_n & if_req_valid & (~d_req_valid | burst_full);
    assign grant_d_p0   = rst_n & d_req_valid & ~(if_req_valid & burst_full);
    assign any_grant_p0 = grant_if_p0 | grant_d_p0;
    assign gnt_addr_p0  = grant_if_p0 ? if_addr : d_addr;
    assign legal_p0     = addr_legal(gnt_addr_p0);

    assign if_req_ready = grant_if_p0;
    assign d_req_ready  = grant_d_p0;

    always_comb begin
        ram_mem_op = MEM_NONE;
        ram_addr   = '0;
        ram_wdata  = '0;
        if (any_grant_p0 && legal_p0) begin
            ram_addr   = gnt_addr_p0;
            ram_wdata  = d_wdata;
            ram_mem_op = (grant_d_p0 && d_we) ? MEM_STORE : MEM_LOAD;
        end
    end

    // Streak is held on idle cycles so a paused data burst still counts against fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant_if_p0) begin
            streak <= '0;
        end else if (grant_d_p0 && !burst_full) begin
            streak <= streak + 4'd1;
        end
    end

    // Stage p1: response ownership, aligned with the RAM's registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner_p1 <= OWN_NONE;
            resp_err_p1   <= 1'b0;
        end else begin
            resp_owner_p1 <= grant_if_p0 ? OWN_IF : (grant_d_p0 ? OWN_D : OWN_NONE);
            resp_err_p1   <= any_grant_p0 & ~legal_p0;
        end
    end

    always_comb begin
        if_resp_valid = (resp_owner_p1 == OWN_IF);
        d_resp_valid  = (resp_owner_p1 == OWN_D);
        if_err        = if_resp_valid & resp_err_p1;
        d_err         = d_resp_valid & resp_err_p1;
        if_rdata      = (if_resp_valid && !resp_err_p1) ? ram_rdata : '0;
        d_rdata       = (d_resp_valid && !resp_err_p1) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural one-cycle-latency RAM.
module tb_ram_arbiter;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    mem_op_e     ram_mem_op;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] mem [0:1023];

    ram_arbiter #(.RAM_WORDS(1024), .MAX_DATA_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_we(d_we), .d_resp_valid(d_resp_valid),
        .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mem_op(ram_mem_op),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, store echoes the written word.
    always @(posedge clk) begin
        if (ram_mem_op == MEM_STORE) begin
            mem[ram_addr[11:2]] <= ram_wdata;
            ram_rdata <= ram_wdata;
        end else if (ram_mem_op == MEM_LOAD) begin
            ram_rdata <= mem[ram_addr[11:2]];
        end else begin
            ram_rdata <= 32'h0;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h40;
        d_req_valid = 1'b1; d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'h5555_AAAA;
        #3;
        n_checks++;
        if ({if_req_ready, d_req_ready} !== 2'b00) begin
            n_fails++; $display("FAIL reset_ready: got %b expected 00", {if_req_ready, d_req_ready});
        end
        n_checks++;
        if ({if_resp_valid, d_resp_valid, if_err, d_err} !== 4'b0000) begin
            n_fails++; $display("FAIL reset_resp_flags: got %b expected 0000",
                                {if_resp_valid, d_resp_valid, if_err, d_err});
        end
        n_checks++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            n_fails++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        end
        n_checks++;
        if ({ram_addr, ram_wdata} !== 64'h0) begin
            n_fails++; $display("FAIL reset_ram_bus: got %h expected 0", {ram_addr, ram_wdata});
        end
        n_checks++;
        if (ram_mem_op !== MEM_NONE) begin
            n_fails++; $display("FAIL reset_mem_op: got %0d expected %0d", ram_mem_op, MEM_NONE);
        end
        @(negedge clk);
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        #1;
        n_checks++;
        if ({if_req_ready, d_req_ready} !== 2'b10) begin
            n_fails++; $display("FAIL fetch_ready: got %b expected 10", {if_req_ready, d_req_ready});
        end
        n_checks++;
        if (ram_mem_op !== MEM_LOAD || ram_addr !== 32'h40) begin
            n_fails++; $display("FAIL fetch_issue: got op %0d addr %h expected op %0d addr 40",
                                ram_mem_op, ram_addr, MEM_LOAD);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        n_checks++;
        if ({if_resp_valid, if_err, d_resp_valid} !== 3'b100) begin
            n_fails++; $display("FAIL fetch_resp_flags: got %b expected 100",
                                {if_resp_valid, if_err, d_resp_valid});
        end
        n_checks++;
        if (if_rdata !== 32'hDEAD_BEEF) begin
            n_fails++; $display("FAIL fetch_rdata: got %h expected deadbeef", if_rdata);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (d_req_ready !== 1'b1 || ram_mem_op !== MEM_STORE || ram_wdata !== 32'h1234_5678
            || ram_addr !== 32'h100) begin
            n_fails++; $display("FAIL store_issue: got rdy %b op %0d addr %h wdata %h expected 1 %0d 100 12345678",
                                d_req_ready, ram_mem_op, ram_addr, ram_wdata, MEM_STORE);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({d_resp_valid, d_err} !== 2'b10 || d_rdata !== 32'h1234_5678) begin
            n_fails++; $display("FAIL store_resp: got v/e %b rdata %h expected 10 12345678",
                                {d_resp_valid, d_err}, d_rdata);
        end
        @(negedge clk);
        d_we = 1'b0; d_wdata = 32'h0;
        #1;
        n_checks++;
        if (ram_mem_op !== MEM_LOAD) begin
            n_fails++; $display("FAIL load_issue: got op %0d expected %0d", ram_mem_op, MEM_LOAD);
        end
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        n_checks++;
        if ({d_resp_valid, d_err} !== 2'b10 || d_rdata !== 32'h1234_5678) begin
            n_fails++; $display("FAIL load_resp: got v/e %b rdata %h expected 10 12345678",
                                {d_resp_valid, d_err}, d_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp_d [12];
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        // single fetch clears streak first
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++;
            if ({if_req_ready, d_req_ready} !== {~exp_d[i], exp_d[i]}) begin
                n_fails++; $display("FAIL contention_grant[%0d]: got if/d %b expected %b",
                                    i, {if_req_ready, d_req_ready}, {~exp_d[i], exp_d[i]});
            end
            @(posedge clk); #1;
            n_checks++;
            if ({if_resp_valid, d_resp_valid} !== {~exp_d[i], exp_d[i]}
                || (exp_d[i] ? d_rdata : if_rdata) !== (exp_d[i] ? 32'h1234_5678 : 32'hDEAD_BEEF)) begin
                n_fails++; $display("FAIL contention_resp[%0d]: got if/d %b if_rdata %h d_rdata %h",
                                    i, {if_resp_valid, d_resp_valid}, if_rdata, d_rdata);
            end
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
    endtask

    task automatic test_illegal();
        @(negedge clk);
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h1002;
        #1;
        n_checks++;
        if (d_req_ready !== 1'b1 || ram_mem_op !== MEM_NONE) begin
            n_fails++; $display("FAIL misaligned_issue: got rdy %b op %0d expected 1 %0d",
                                d_req_ready, ram_mem_op, MEM_NONE);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({d_resp_valid, d_err} !== 2'b11 || d_rdata !== 32'h0) begin
            n_fails++; $display("FAIL misaligned_resp: got v/e %b rdata %h expected 11 0",
                                {d_resp_valid, d_err}, d_rdata);
        end
        @(negedge clk);
        d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hCAFE_F00D;
        #1;
        n_checks++;
        if (d_req_ready !== 1'b1 || ram_mem_op !== MEM_NONE) begin
            n_fails++; $display("FAIL range_issue: got rdy %b op %0d expected 1 %0d",
                                d_req_ready, ram_mem_op, MEM_NONE);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({d_resp_valid, d_err, if_resp_valid} !== 3'b110 || d_rdata !== 32'h0) begin
            n_fails++; $display("FAIL range_resp: got v/e/if %b rdata %h expected 110 0",
                                {d_resp_valid, d_err, if_resp_valid}, d_rdata);
        end
        // word 0 aliases 0x1000 in the RAM model, so an escaped store would show here
        @(negedge clk);
        d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        n_checks++;
        if ({d_resp_valid, d_err} !== 2'b10 || d_rdata !== 32'hA5A5_A5A5) begin
            n_fails++; $display("FAIL ram_unchanged: got v/e %b rdata %h expected 10 a5a5a5a5",
                                {d_resp_valid, d_err}, d_rdata);
        end
    endtask

    task automatic test_streak_persist();
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        if_req_valid = 1'b0;
        d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        repeat (3) @(negedge clk);
        d_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        n_checks++;
        if ({if_req_ready, d_req_ready} !== 2'b01) begin
            n_fails++; $display("FAIL streak_fourth_data: got if/d %b expected 01", {if_req_ready, d_req_ready});
        end
        @(negedge clk); #1;
        n_checks++;
        if ({if_req_ready, d_req_ready} !== 2'b10) begin
            n_fails++; $display("FAIL streak_fetch_turn: got if/d %b expected 10", {if_req_ready, d_req_ready});
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if_req_valid = 1'b1; if_addr = 32'h40;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if_resp_valid, if_err, if_rdata} !== 34'h0) begin
            n_fails++; $display("FAIL midreset_resp: got v %b err %b rdata %h expected 0",
                                if_resp_valid, if_err, if_rdata);
        end
        n_checks++;
        if ({if_req_ready, d_req_ready} !== 2'b00 || ram_mem_op !== MEM_NONE || ram_addr !== 32'h0) begin
            n_fails++; $display("FAIL midreset_req: got rdy %b op %0d addr %h expected 00 %0d 0",
                                {if_req_ready, d_req_ready}, ram_mem_op, ram_addr, MEM_NONE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({if_req_ready, if_resp_valid, d_resp_valid} !== 3'b100 || ram_mem_op !== MEM_LOAD) begin
            n_fails++; $display("FAIL postreset_issue: got rdy/ifv/dv %b op %0d expected 100 %0d",
                                {if_req_ready, if_resp_valid, d_resp_valid}, ram_mem_op, MEM_LOAD);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        n_checks++;
        if ({if_resp_valid, if_err} !== 2'b10 || if_rdata !== 32'hDEAD_BEEF) begin
            n_fails++; $display("FAIL postreset_resp: got v/e %b rdata %h expected 10 deadbeef",
                                {if_resp_valid, if_err}, if_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]     = 32'hA5A5_A5A5;
        mem[10'h10] = 32'hDEAD_BEEF;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_illegal();
        test_streak_persist();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
